fwd_scoreboard: RTL
===================

FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 Parameter: LOAD_LAT, default 2, number of stall cycles before a load result reaches a forwarding point (range 0..7).
REQ-002 Parameter: ALU_LAT, default 0, number of stall cycles before a non-load result reaches a forwarding point (range 0..7).
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-low; asserted when 0.
REQ-005 issue_valid  input  1  instruction presented for operand read.
REQ-006 issue_rs, issue_rt  input  5 each  source register numbers.
REQ-007 issue_uses_rs, issue_uses_rt  input  1 each  the instruction actually reads that source.
REQ-008 issue_dst  input  5  destination register.
REQ-009 issue_regwrite, issue_is_load  input  1 each  the instruction writes issue_dst; the producer is a load.
REQ-010 flush  input  1  kill all in-flight producers.
REQ-011 ex_reg/ex_data/ex_we, mem_reg/mem_data/mem_we, wb_reg/wb_data/wb_we, wbfw_reg/wbfw_data/wbfw_we  input  5/32/1 each  forwarding sources; wbfw is the one-cycle-delayed writeback copy.
REQ-012 rf_rs_data, rf_rt_data  input  32 each  register-file read data.
REQ-013 issue_stall  output  1  combinational; instruction not accepted this cycle.
REQ-014 op_valid_out  output  1  registered; operands are valid.
REQ-015 op_a_out, op_b_out  output  32 each  registered resolved rs and rt operands.
REQ-016 stall_cycles  output  16  registered count of stalled cycles, saturating.

Function
REQ-017 The block SHALL hold 32 scoreboard counters, 3 bits each, pend[0..31].
REQ-018 issue_stall SHALL be 1 iff issue_valid and ((issue_uses_rs and issue_rs!=0 and pend[issue_rs]!=0) or (issue_uses_rt and issue_rt!=0 and pend[issue_rt]!=0)) and flush==0.
REQ-019 Accept = issue_valid and not issue_stall and not flush.
REQ-020 On each posedge, every nonzero pend[i] SHALL decrement by 1.
REQ-021 On accept with issue_regwrite=1 and issue_dst!=0, pend[issue_dst] SHALL load LOAD_LAT if issue_is_load, otherwise ALU_LAT; this load overrides the decrement for that entry in the same cycle.
REQ-022 pend[0] SHALL always read 0 and is never written.
REQ-023 Operand resolution for each source SHALL use fixed priority: register 0 gives 0; then ex (ex_we and ex_reg match); then mem; then wb; then wbfw; then rf data.
REQ-024 On accept, op_a_out/op_b_out SHALL capture the resolved rs/rt values on the next posedge, and op_valid_out SHALL be 1.
REQ-025 When not accepting, op_valid_out SHALL be 0 on the next posedge, and op_a_out/op_b_out SHALL hold their values.
REQ-026 flush=1 SHALL clear every pend entry and force op_valid_out=0 on the next posedge, taking priority over any issue in that cycle.
REQ-027 stall_cycles SHALL increment on each cycle with issue_stall=1 and hold at 16'hFFFF.
REQ-028 Latency: one cycle from accept to op_valid_out; a consumer of a load issued at cycle t is accepted no earlier than t+1+LOAD_LAT.

Reset
REQ-029 While reset=0, asynchronously: all pend entries=0, op_valid_out=0, op_a_out=0, op_b_out=0, stall_cycles=0.
REQ-030 The first accept SHALL be possible on the first posedge after reset deasserts; issue_stall SHALL be 0 out of reset.
REQ-031 Reset asserted mid-stall SHALL discard all pending state; no stall persists after release.

Verification
REQ-032 ALU back-to-back: add r3 (ALU_LAT=0), then next-cycle consumer reads r3 with ex_reg=3, ex_data=0x11 -> no stall; op_a_out=0x11.
REQ-033 Load-use: load r5 at t, consumer of r5 at t+1 -> issue_stall=1 at t+1 and t+2; accepted at t+3 with wbfw_data=0xABCD as the only match -> op_a_out=0xABCD; stall_cycles=2.
REQ-034 Priority: ex, mem, and wb all target r7 with data 1, 2, 3 -> operand=1; with ex_we=0 -> operand=2.
REQ-035 r0: issue_rs=0, ex_reg=0, ex_we=1, ex_data=0xFF -> op_a_out=0; load to r0 -> no stall on later r0 readers.
REQ-036 Flush: load r9, then flush the next cycle -> pend[9]=0; a r9 reader the following cycle is accepted with op_valid_out=1; a flush coincident with issue -> op_valid_out=0.
REQ-037 Reset mid-operation: pend[4]=2, then reset low for one cycle -> all outputs 0, and a r4 reader after release is not stalled.

Source files
------------

// File: rtl/fwd_scoreboard.sv
// Operand-forwarding scoreboard: tracks producer latency per register, stalls
// unready readers, and resolves operands from the forwarding network or the RF.
module fwd_scoreboard #(
  parameter int unsigned LOAD_LAT = 2,
  parameter int unsigned ALU_LAT  = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rs,
  input  logic [4:0]  issue_rt,
  input  logic        issue_uses_rs,
  input  logic        issue_uses_rt,
  input  logic [4:0]  issue_dst,
  input  logic        issue_regwrite,
  input  logic        issue_is_load,
  input  logic        flush,
  input  logic [4:0]  ex_reg,
  input  logic [31:0] ex_data,
  input  logic        ex_we,
  input  logic [4:0]  mem_reg,
  input  logic [31:0] mem_data,
  input  logic        mem_we,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  input  logic        wb_we,
  input  logic [4:0]  wbfw_reg,
  input  logic [31:0] wbfw_data,
  input  logic        wbfw_we,
  input  logic [31:0] rf_rs_data,
  input  logic [31:0] rf_rt_data,
  output logic        issue_stall,
  output logic        op_valid_out,
  output logic [31:0] op_a_out,
  output logic [31:0] op_b_out,
  output logic [15:0] stall_cycles
);

  localparam int unsigned DW   = 32;
  localparam int unsigned RW   = 5;
  localparam int unsigned CW   = 3;
  localparam int unsigned SW   = 16;
  localparam int unsigned NREG = 32;

  localparam logic [CW-1:0] LOAD_CNT = CW'(LOAD_LAT);
  localparam logic [CW-1:0] ALU_CNT  = CW'(ALU_LAT);
  localparam logic [SW-1:0] SC_MAX   = '1;

  logic [CW-1:0] pend [NREG];
  logic          rs_busy_c;
  logic          rt_busy_c;
  logic          accept_c;
  logic [DW-1:0] op_a_c;
  logic [DW-1:0] op_b_c;

  // Fixed-priority operand source select: r0, ex, mem, wb, wbfw, then RF.
  function automatic logic [DW-1:0] resolve(input logic [RW-1:0] r,
                                            input logic [DW-1:0] rf);
    logic [DW-1:0] v;
    if (r == '0)                        v = '0;
    else if (ex_we   && ex_reg   == r)  v = ex_data;
    else if (mem_we  && mem_reg  == r)  v = mem_data;
    else if (wb_we   && wb_reg   == r)  v = wb_data;
    else if (wbfw_we && wbfw_reg == r)  v = wbfw_data;
    else                                v = rf;
    return v;
  endfunction

  // Hazard detection, accept decision and operand resolution.
  always_comb begin
    rs_busy_c   = 1'b0;
    rt_busy_c   = 1'b0;
    issue_stall = 1'b0;
    accept_c    = 1'b0;
    rs_busy_c   = issue_uses_rs && (issue_rs != '0) && (pend[issue_rs] != '0);
    rt_busy_c   = issue_uses_rt && (issue_rt != '0) && (pend[issue_rt] != '0);
    issue_stall = issue_valid && (rs_busy_c || rt_busy_c) && !flush;
    accept_c    = issue_valid && !issue_stall && !flush;
    op_a_c      = resolve(issue_rs, rf_rs_data);
    op_b_c      = resolve(issue_rt, rf_rt_data);
  end

  // Scoreboard counters: count down each cycle, reload on accepted writer, clear on flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) pend[i] <= '0;
    end else if (flush) begin
      for (int i = 1; i < NREG; i++) pend[i] <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (accept_c && issue_regwrite && (issue_dst == RW'(i)))
          pend[i] <= issue_is_load ? LOAD_CNT : ALU_CNT;
        else if (pend[i] != '0)
          pend[i] <= pend[i] - CW'(1);
      end
    end
  end

  // Registered operand outputs and saturating stall counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_valid_out <= 1'b0;
      op_a_out     <= '0;
      op_b_out     <= '0;
      stall_cycles <= '0;
    end else begin
      op_valid_out <= accept_c;
      if (accept_c) begin
        op_a_out <= op_a_c;
        op_b_out <= op_b_c;
      end
      if (issue_stall && (stall_cycles != SC_MAX))
        stall_cycles <= stall_cycles + SW'(1);
    end
  end

endmodule
